rv_fetch_unit: RTL and testbench

- Instruction fetch front end for the riscv32 core; the producer side of the opcode interface consumed by the control unit.
- Holds the PC, issues word requests to instruction memory over a valid/ready request channel and accepts a valid-only response.
- Presents one fetched instruction and its PC to decode through a valid/ready output buffer.
- Applies PC redirects from branch/jump resolution and discards any in-flight stale fetch.

---
 rtl/rv_fetch_unit.sv | 123 ++++++++++++
 tb/tb_rv_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch_unit.sv
// Instruction fetch front end: owns the PC and fetches one word at a time from instruction memory.
// It hands each instruction to decode through a valid/ready buffer and discards fetches made stale by a redirect.
module rv_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] pc_req, pc_req_n;
  logic [XLEN-1:0] inst_q, inst_q_n;
  logic [XLEN-1:0] inst_pc_q, inst_pc_q_n;
  logic            kill, kill_n;
  logic [XLEN-1:0] redirect_aligned;
  state_t          after_done;

  assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
  assign after_done       = fetch_en ? REQ : IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      pc_req    <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      kill      <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      pc_req    <= pc_req_n;
      inst_q    <= inst_q_n;
      inst_pc_q <= inst_pc_q_n;
      kill      <= kill_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    pc_req_n    = pc_req;
    inst_q_n    = inst_q;
    inst_pc_q_n = inst_pc_q;
    kill_n      = kill;
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          pc_n    = redirect_aligned;
          state_n = after_done;
        end else if (fetch_en) begin
          state_n = REQ;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          pc_n = redirect_aligned;
          // A request accepted in the redirect cycle is already in flight; mark it stale.
          if (imem_req_ready) begin
            state_n = WAIT;
            kill_n  = 1'b1;
          end
        end else if (imem_req_ready) begin
          pc_req_n = pc;
          state_n  = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_n = redirect_aligned;
          if (imem_rsp_valid) begin
            kill_n  = 1'b0;
            state_n = after_done;
          end else begin
            kill_n = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (kill) begin
            kill_n  = 1'b0;
            state_n = after_done;
          end else begin
            inst_q_n    = imem_rsp_data;
            inst_pc_q_n = pc_req;
            pc_n        = pc_req + XLEN'(4);
            state_n     = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_n    = redirect_aligned;
          state_n = after_done;
        end else if (inst_ready) begin
          state_n = after_done;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign imem_req_valid = (state == REQ);
  assign imem_addr      = {pc[XLEN-1:2], 2'b00};
  assign inst_valid     = (state == HOLD);
  assign inst           = inst_valid ? inst_q : '0;
  assign inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Scoreboard bench for rv_fetch_unit: directed scenarios push expected {pc, inst} pairs,
// a monitor pops them on each decode handshake; a small memory model answers requests.
module tb_rv_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] sb[$];
  int          mem_lat  = 1;

  rv_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory contents: address-tagged words, except a NOP-like 0x13 at address 4.
  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h4) return 32'h0000_0013;
    return a ^ 32'hC0DE_0000;
  endfunction

  // Instruction memory: answers mem_lat cycles after acceptance.
  initial begin
    logic        hs;
    logic [31:0] ha;
    int          pend_cnt;
    logic [31:0] pend_data;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    pend_cnt       = 0;
    pend_data      = '0;
    forever begin
      @(negedge clk);
      hs = imem_req_valid && imem_req_ready && !rst;
      ha = imem_addr;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (hs) begin
        pend_cnt  = mem_lat;
        pend_data = word(ha);
      end
      if (pend_cnt > 0) begin
        if (pend_cnt == 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = pend_data;
        end
        pend_cnt--;
      end
    end
  end

  // Monitor: compares every decode handshake against the scoreboard.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (inst_valid && inst_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_inst actual_pc=%h actual_inst=%h required=none", inst_pc, inst);
          end else begin
            e = sb.pop_front();
            chk("inst_pc", inst_pc, e[63:32]);
            chk("inst", inst, e[31:0]);
          end
        end else if (!inst_valid) begin
          chk("inst_zero_when_invalid", inst, 32'h0);
        end
      end
    end
  end

  // Waits for the given instruction to be held, then stops further fetching.
  task automatic wait_inst(input string name, input logic [31:0] pc);
    logic found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (inst_valid && inst_pc == pc) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    fetch_en = 1'b0;
    chk(name, {31'b0, found}, 32'h1);
  endtask

  task automatic wait_req(input string name);
    logic found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk(name, {31'b0, found}, 32'h1);
  endtask

  initial begin
    rst            = 1'b1;
    fetch_en       = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (3) tick();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_addr", imem_addr, 32'hFFFF_FFFC);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    rst = 1'b0;
    tick();

    // Zero-wait stream from RESET_PC, wrapping through 0.
    sb.push_back({32'hFFFF_FFFC, 32'h3F21_FFFC});
    sb.push_back({32'h0000_0000, 32'hC0DE_0000});
    sb.push_back({32'h0000_0004, 32'h0000_0013});
    sb.push_back({32'h0000_0008, 32'hC0DE_0008});
    fetch_en = 1'b1;
    tick();
    wait_req("s1_req_timeout");
    chk("s1_first_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("s1_valid_n1", {31'b0, inst_valid}, 32'h0);
    chk("s1_req_valid_wait", {31'b0, imem_req_valid}, 32'h0);
    tick();
    chk("s1_valid_n2", {31'b0, inst_valid}, 32'h1);
    wait_inst("s1_inst8_timeout", 32'h8);
    repeat (3) tick();
    chk("s1_idle", {31'b0, imem_req_valid}, 32'h0);

    // Request held while memory is not ready.
    imem_req_ready = 1'b0;
    fetch_en       = 1'b1;
    sb.push_back({32'h0000_000C, 32'hC0DE_000C});
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("s2_hold_valid", {31'b0, imem_req_valid}, 32'h1);
      chk("s2_hold_addr", imem_addr, 32'h0000_000C);
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    chk("s2_accepted", {31'b0, imem_req_valid}, 32'h0);
    fetch_en = 1'b0;
    repeat (4) tick();
    chk("s2_no_refetch", {31'b0, imem_req_valid}, 32'h0);

    // Redirect from IDLE to 0x4, then stall decode on the held instruction.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4;
    tick();
    redirect_valid = 1'b0;
    chk("s3_idle_after_redirect", {31'b0, imem_req_valid}, 32'h0);
    inst_ready = 1'b0;
    fetch_en   = 1'b1;
    sb.push_back({32'h0000_0004, 32'h0000_0013});
    wait_inst("s3_inst_timeout", 32'h4);
    fetch_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("s3_stall_valid", {31'b0, inst_valid}, 32'h1);
      chk("s3_stall_inst", inst, 32'h0000_0013);
      chk("s3_stall_pc", inst_pc, 32'h4);
      chk("s3_stall_noreq", {31'b0, imem_req_valid}, 32'h0);
    end
    fetch_en   = 1'b0;
    inst_ready = 1'b1;
    tick();
    chk("s3_released", {31'b0, inst_valid}, 32'h0);
    chk("s3_released_inst", inst, 32'h0);

    // Redirect while waiting; the late stale response must be dropped.
    mem_lat  = 3;
    fetch_en = 1'b1;
    tick();
    chk("s4_req_addr", imem_addr, 32'h8);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    tick();
    redirect_valid = 1'b0;
    mem_lat        = 1;
    sb.push_back({32'h0000_0100, 32'hC0DE_0100});
    for (int i = 0; i < 2; i++) begin
      chk("s4_no_stale_valid", {31'b0, inst_valid}, 32'h0);
      tick();
    end
    wait_req("s4_req_timeout");
    chk("s4_redirect_addr", imem_addr, 32'h100);
    wait_inst("s4_inst_timeout", 32'h100);
    repeat (3) tick();

    // Redirect coinciding with the response.
    fetch_en = 1'b1;
    tick();
    chk("s5_req_addr", imem_addr, 32'h104);
    tick();
    chk("s5_in_wait", {31'b0, imem_req_valid}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("s5_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("s5_req_addr_new", imem_addr, 32'h200);
    sb.push_back({32'h0000_0200, 32'hC0DE_0200});
    wait_inst("s5_inst_timeout", 32'h200);
    repeat (3) tick();

    // Asynchronous reset while waiting on a slow response.
    mem_lat  = 4;
    fetch_en = 1'b1;
    tick();
    chk("s6_req_addr", imem_addr, 32'h204);
    tick();
    fetch_en = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("s6_async_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("s6_async_addr", imem_addr, 32'hFFFF_FFFC);
    chk("s6_async_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("s6_async_inst_pc", inst_pc, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("s6_late_rsp_ignored", {31'b0, inst_valid}, 32'h0);
    chk("s6_idle_noreq", {31'b0, imem_req_valid}, 32'h0);
    mem_lat  = 1;
    fetch_en = 1'b1;
    sb.push_back({32'hFFFF_FFFC, 32'h3F21_FFFC});
    sb.push_back({32'h0000_0000, 32'hC0DE_0000});
    tick();
    wait_req("s6_req_timeout");
    chk("s6_restart_addr", imem_addr, 32'hFFFF_FFFC);
    wait_inst("s6_inst_timeout", 32'h0);
    repeat (5) tick();

    chk("sb_drained", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
